rf_dbg_access_rv32i: RTL
========================

# rf_dbg_access_rv32i

Debug access initiator for the RV32I 32x32 register file. It accepts single read or write requests from a debug host over a valid/ready handshake and drives the register file's write port and read port 1. It returns read data through a response handshake, and optionally streams out all 32 registers in one dump sequence. It sits beside the core datapath; the top level muxes the register-file address and write ports to this block whenever `dbg_active` is high.

## Interface
Parameters: none; widths are fixed by RV32I.
- `clock` in 1: global clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 5: register index.
- `req_wdata` in 32: write data.
- `dump_start` in 1: one-cycle pulse; starts a full dump. Only honoured in IDLE.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: host accepts response.
- `resp_rdata` out 32: read data; 0 for writes.
- `resp_addr` out 5: register index this response refers to.
- `resp_last` out 1: final response of a dump.
- `dbg_active` out 1: high in any state other than IDLE.
- `rf_rdwrite` out 1: to register file write enable.
- `rf_rd_addr` out 5: to register file write address.
- `rf_rd_in` out 32: to register file write data.
- `rf_rs1_addr` out 5: to register file read address, port 1.
- `rf_rs1` in 32: from register file read data, port 1. This port is updated on negedge.

## Operation
- FSM states: IDLE, WR, RD, RESP.
- IDLE:
  - `req_ready`=1.
  - If `req_valid` is high, latch addr/data/write and go to WR (write) or RD (read).
  - Else, if `dump_start` is high (build-dependent), set index=0, dump=1, and go to RD.
  - `req_valid` has priority over `dump_start` when both arrive in the same cycle.
- WR (1 cycle):
  - Drive `rf_rdwrite`=1, `rf_rd_addr`=addr, `rf_rd_in`=wdata.
  - If addr==0, `rf_rdwrite` stays 0; the request is still acknowledged.
  - Go to RESP with `resp_rdata`=0.
- RD (1 cycle):
  - Drive `rf_rs1_addr`=index.
  - The register file loads `rf_rs1` at the mid-cycle negedge.
  - At the closing posedge, capture `rf_rs1` into `resp_rdata` and go to RESP.
- RESP:
  - Hold `resp_valid`=1 with `resp_addr`, `resp_rdata`, and `resp_last` stable until `resp_ready` is high.
  - On handshake, a single request returns to IDLE.
  - On handshake during a dump: if index==31, return to IDLE and clear dump; else increment index and go to RD.
- `resp_last`=1 only in RESP with dump=1 and index==31.
- The index is 5 bits. The dump terminates at 31 and never wraps to 0.
- `req_ready`=0 outside IDLE. Requests presented during busy states are simply not accepted, and the host must hold them.
- All `rf_*` outputs are registered. When not in WR or RD, `rf_rdwrite`=0 and addresses/data are 0.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_addr`=0, `resp_last`=0, `dbg_active`=0, `rf_rdwrite`=0, `rf_rd_addr`=0, `rf_rd_in`=0, `rf_rs1_addr`=0, dump=0, index=0.
- Write: accept at edge E0; WR during E0–E1, and the register file commits at E1; `resp_valid` rises after E1.
- Read: accept at E0; RD during E0–E1; `resp_valid` rises after E1 carrying the register value as of the negedge inside the RD cycle.
- A write followed by a read of the same register returns the new value, because the write commits at E1 and the next RD negedge is later.
- Dump throughput: 2 cycles per register when `resp_ready` is held at 1, i.e. 64 cycles total.
- Reset mid-operation, in any state: the next edge forces reset values. Any in-flight response is dropped, any dump is aborted, and no write is issued.
- `resp_ready` held high in advance completes the handshake in RESP's first cycle.

## Configuration
- `RF_DBG_DUMP_EN` defined: dump mode is compiled in as described above.
- Undefined:
  - The dump logic and index counter are removed.
  - `dump_start` is ignored.
  - `resp_last` is tied to 0.
  - `resp_addr` always equals the latched `req_addr`.
  - The ports are unchanged.

## Test plan
- After reset, check every output at its reset value. Write addr=5, data=0xDEADBEEF: `rf_rdwrite` pulses for exactly 1 cycle with `rf_rd_addr`=5; the response has `resp_rdata`=0 and `resp_addr`=5.
- Read addr=5 right after that write: `resp_rdata`=0xDEADBEEF, `resp_valid` 2 cycles after acceptance.
- Write addr=0, data=0x12345678: response is returned but `rf_rdwrite` stays 0. A following read of addr=0 returns 0.
- Hold `resp_ready`=0 for 5 cycles in RESP: `resp_valid`, `resp_rdata`, and `resp_addr` are stable, and `req_ready`=0 throughout.
- With `RF_DBG_DUMP_EN`, preload x_i=i*0x01010101 and pulse `dump_start`: 32 responses with addr 0..31 and matching data; `resp_last` is high only on addr 31; then IDLE, `dbg_active`=0.
- Assert reset during RD of a dump at index 10: the next cycle shows reset values and no further responses; a subsequent read of addr 3 behaves normally.

Source files
------------

// File: rtl/rf_dbg_access_rv32i.sv
// -----------------------------------------------------------------------------
// rf_dbg_access_rv32i
//
// Debug access initiator for the RV32I 32x32 register file. A debug host
// issues single read or write requests over a valid/ready handshake; this
// block drives the register file write port and read port 1, then returns a
// response over a second valid/ready handshake. It can also walk all 32
// registers and stream them out as one dump sequence.
//
// The surrounding top level hands the register file address/write ports to
// this block whenever dbg_active is high.
//
// Build option:
//   RF_DBG_DUMP_EN  defined   -> full-register dump mode compiled in
//                   undefined -> dump logic and index counter removed,
//                                dump_start ignored, resp_last tied low,
//                                resp_addr is the latched request address
//
// Ports:
//   clock        in   1  global clock, all state changes on posedge
//   reset        in   1  synchronous active-high reset
//   req_valid    in   1  host request valid
//   req_ready    out  1  block can accept a request (only in IDLE)
//   req_write    in   1  1 = write, 0 = read
//   req_addr     in   5  register index
//   req_wdata    in  32  write data
//   dump_start   in   1  one-cycle pulse starting a full dump (IDLE only)
//   resp_valid   out  1  response valid
//   resp_ready   in   1  host accepts response
//   resp_rdata   out 32  read data, 0 for writes
//   resp_addr    out  5  register index the response refers to
//   resp_last    out  1  final response of a dump
//   dbg_active   out  1  block owns the register file ports (not IDLE)
//   rf_rdwrite   out  1  register file write enable (registered)
//   rf_rd_addr   out  5  register file write address (registered)
//   rf_rd_in     out 32  register file write data (registered)
//   rf_rs1_addr  out  5  register file read address, port 1 (registered)
//   rf_rs1       in  32  register file read data, port 1 (valid after negedge)
// -----------------------------------------------------------------------------

`default_nettype none

module rf_dbg_access_rv32i (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic        dump_start,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_addr,
    output logic        resp_last,
    output logic        dbg_active,
    output logic        rf_rdwrite,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_rd_in,
    output logic [4:0]  rf_rs1_addr,
    input  logic [31:0] rf_rs1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [4:0] LAST_INDEX = 5'd31;

    state_t      state_q;
    state_t      state_d;

    // Register index for the transaction in flight. For single requests it
    // holds the latched req_addr; during a dump it is the walking index.
    logic [4:0]  addr_q;
    logic [4:0]  addr_d;

    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    logic        rdwrite_q;
    logic        rdwrite_d;
    logic [4:0]  rd_addr_q;
    logic [4:0]  rd_addr_d;
    logic [31:0] rd_in_q;
    logic [31:0] rd_in_d;
    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs1_addr_d;

`ifdef RF_DBG_DUMP_EN
    logic        dump_q;
    logic        dump_d;
    logic        dump_continue;

    // A dump keeps going after a handshake unless the index just served was
    // the final register; it never wraps back to 0.
    assign dump_continue = dump_q && (addr_q != LAST_INDEX);
`else
    // Dump mode is not built; the pin is kept so the port list is identical.
    logic        unused_dump_start;
    assign unused_dump_start = dump_start;
`endif

    // State register plus every registered output. A synchronous reset
    // drops any in-flight response, aborts a dump and guarantees no write
    // enable is driven on the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 5'd0;
            rdata_q    <= 32'd0;
            rdwrite_q  <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_in_q    <= 32'd0;
            rs1_addr_q <= 5'd0;
`ifdef RF_DBG_DUMP_EN
            dump_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            rdwrite_q  <= rdwrite_d;
            rd_addr_q  <= rd_addr_d;
            rd_in_q    <= rd_in_d;
            rs1_addr_q <= rs1_addr_d;
`ifdef RF_DBG_DUMP_EN
            dump_q     <= dump_d;
`endif
        end
    end

    // Next-state logic. A host request beats dump_start when both appear in
    // the same IDLE cycle. WR and RD always last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_write ? WR : RD;
                end
`ifdef RF_DBG_DUMP_EN
                else if (dump_start) begin
                    state_d = RD;
                end
`endif
            end
            WR: begin
                state_d = RESP;
            end
            RD: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
`ifdef RF_DBG_DUMP_EN
                    state_d = dump_continue ? RD : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs and datapath. The rf_* ports
    // are computed one cycle ahead so they are already driven from the edge
    // that enters WR or RD; they fall back to zero in every other state.
    // Because the register file updates rf_rs1 on the negedge inside RD, the
    // value is stable by the posedge that closes RD and is captured then.
    always_comb begin
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        rdwrite_d  = 1'b0;
        rd_addr_d  = 5'd0;
        rd_in_d    = 32'd0;
        rs1_addr_d = 5'd0;
`ifdef RF_DBG_DUMP_EN
        dump_d     = dump_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        // x0 is hardwired to zero, so a write to it is
                        // acknowledged without ever raising the enable.
                        rdwrite_d = (req_addr != 5'd0);
                        rd_addr_d = req_addr;
                        rd_in_d   = req_wdata;
                    end else begin
                        rs1_addr_d = req_addr;
                    end
                end
`ifdef RF_DBG_DUMP_EN
                else if (dump_start) begin
                    addr_d     = 5'd0;
                    dump_d     = 1'b1;
                    rs1_addr_d = 5'd0;
                end
`endif
            end
            WR: begin
                rdata_d = 32'd0;
            end
            RD: begin
                rdata_d = rf_rs1;
            end
            RESP: begin
`ifdef RF_DBG_DUMP_EN
                if (resp_ready) begin
                    if (dump_continue) begin
                        addr_d     = addr_q + 5'd1;
                        rs1_addr_d = addr_q + 5'd1;
                    end else begin
                        dump_d = 1'b0;
                    end
                end
`endif
            end
            default: begin
                rdata_d = rdata_q;
            end
        endcase
    end

    // Handshake and status outputs decode directly from the state register,
    // so they are glitch-free and change only on clock edges.
    always_comb begin
        req_ready  = (state_q == IDLE);
        dbg_active = (state_q != IDLE);
        resp_valid = (state_q == RESP);
`ifdef RF_DBG_DUMP_EN
        resp_last  = (state_q == RESP) && dump_q && (addr_q == LAST_INDEX);
`else
        resp_last  = 1'b0;
`endif
    end

    assign resp_rdata  = rdata_q;
    assign resp_addr   = addr_q;
    assign rf_rdwrite  = rdwrite_q;
    assign rf_rd_addr  = rd_addr_q;
    assign rf_rd_in    = rd_in_q;
    assign rf_rs1_addr = rs1_addr_q;

endmodule

`default_nettype wire
